// File: rtl/ram_read_streamer.sv
// ram_read_streamer: read-side sequencer for dual_clk_ram's read port.
// Issues ram_read_addr = base, base+1, ... for length beats. It accounts for
// the fixed RAM read latency with a shift pipe of issue tags, and captures the
// returned words in a small output FIFO presented as a valid/ready stream.
// An address is only issued while FIFO occupancy plus words still in flight
// leaves room, so returned data is never dropped under backpressure.
//
// Optional build macro RAM_READ_STREAMER_LOOP_EN: adds a 'loop' input sampled
// with start. When looping, the sweep restarts at the latched base without a
// gap. A later start with loop=0 ends the loop after the current pass.
module ram_read_streamer #(
  parameter int DATA_WIDTH      = 8,
  parameter int ADDR_WIDTH      = 12,
  parameter int LEN_WIDTH       = 13,
  parameter int READ_LATENCY    = 2,
  parameter int FIFO_DEPTH_LOG2 = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [LEN_WIDTH-1:0]  length,
`ifdef RAM_READ_STREAMER_LOOP_EN
  input  logic                  loop,
`endif
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] ram_read_addr,
  input  logic [DATA_WIDTH-1:0] ram_data,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last
);

  // state  | meaning
  // IDLE   | waiting for start
  // ISSUE  | presenting read addresses, gated by FIFO credit
  // DRAIN  | all addresses issued, waiting for the final beat to leave
  // FINISH | one-cycle done pulse, then back to IDLE

  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam int CNT_W = FIFO_DEPTH_LOG2 + 1;
  localparam int INF_W = $clog2(READ_LATENCY + 1);
  localparam int OCC_W = $clog2(DEPTH + READ_LATENCY + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    DRAIN  = 2'd2,
    FINISH = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [LEN_WIDTH-1:0]       remaining_q;
  logic [READ_LATENCY-1:0]    pipe_vld_q;
  logic [READ_LATENCY-1:0]    pipe_last_q;

  logic [DATA_WIDTH-1:0]      fifo_data_q [DEPTH];
  logic [DEPTH-1:0]           fifo_last_q;
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr_q;
  logic [FIFO_DEPTH_LOG2-1:0] rd_ptr_q;
  logic [CNT_W-1:0]           fifo_count_q;

  logic [INF_W-1:0]           inflight;
  logic [OCC_W-1:0]           occupancy;
  logic                       start_acc;
  logic                       issue;
  logic                       last_issue;
  logic                       reload;
  logic                       push;
  logic                       pop;
  logic                       final_pop;

`ifdef RAM_READ_STREAMER_LOOP_EN
  logic                       loop_q;
  logic [ADDR_WIDTH-1:0]      base_q;
  logic [LEN_WIDTH-1:0]       len_q;
`endif

  assign start_acc  = (state_q == IDLE) && start;
  assign occupancy  = OCC_W'(fifo_count_q) + OCC_W'(inflight);
  assign issue      = (state_q == ISSUE) && (remaining_q != '0) &&
                      (occupancy < OCC_W'(DEPTH));
  assign last_issue = issue && (remaining_q == LEN_WIDTH'(1));
  assign push       = pipe_vld_q[READ_LATENCY-1];
  assign m_valid    = (fifo_count_q != '0);
  assign pop        = m_valid && m_ready;
  assign m_data     = m_valid ? fifo_data_q[rd_ptr_q] : '0;
  assign m_last     = m_valid & fifo_last_q[rd_ptr_q];

  // The transfer is over only when the tagged last word leaves and nothing
  // else is queued or in flight (an earlier looped pass may also carry a tag).
  assign final_pop  = pop && m_last && (fifo_count_q == CNT_W'(1)) &&
                      (pipe_vld_q == '0);

`ifdef RAM_READ_STREAMER_LOOP_EN
  assign reload = last_issue && loop_q;
`else
  assign reload = 1'b0;
`endif

  // Words in flight: set bits in the issue pipe.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < READ_LATENCY; i++) begin
      inflight = inflight + INF_W'(pipe_vld_q[i]);
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and status outputs.
  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = (length == '0) ? FINISH : ISSUE;
        end
      end
      ISSUE: begin
        busy = 1'b1;
        if (last_issue && !reload) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        busy = 1'b1;
        if (final_pop) begin
          state_d = FINISH;
        end
      end
      FINISH: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Read address and remaining-issue down-counter; the address holds after
  // the final issue so the RAM simply re-reads it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ram_read_addr <= '0;
      remaining_q   <= '0;
    end else if (start_acc && (length != '0)) begin
      ram_read_addr <= base_addr;
      remaining_q   <= length;
    end else if (issue) begin
`ifdef RAM_READ_STREAMER_LOOP_EN
      if (reload) begin
        ram_read_addr <= base_q;
        remaining_q   <= len_q;
      end else
`endif
      if (last_issue) begin
        remaining_q   <= '0;
      end else begin
        ram_read_addr <= ram_read_addr + ADDR_WIDTH'(1);
        remaining_q   <= remaining_q - LEN_WIDTH'(1);
      end
    end
  end

`ifdef RAM_READ_STREAMER_LOOP_EN
  // Loop control: base/length kept for reloads; a start with loop=0 while
  // busy stops looping at the end of the current pass.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      loop_q <= 1'b0;
      base_q <= '0;
      len_q  <= '0;
    end else if (start_acc) begin
      loop_q <= loop && (length != '0);
      base_q <= base_addr;
      len_q  <= length;
    end else if (busy && start && !loop) begin
      loop_q <= 1'b0;
    end
  end
`endif

  // Issue pipe: tracks which cycles will return a word, and which is last.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pipe_vld_q  <= '0;
      pipe_last_q <= '0;
    end else begin
      pipe_vld_q[0]  <= issue;
      pipe_last_q[0] <= last_issue;
      for (int i = 1; i < READ_LATENCY; i++) begin
        pipe_vld_q[i]  <= pipe_vld_q[i-1];
        pipe_last_q[i] <= pipe_last_q[i-1];
      end
    end
  end

  // Output FIFO storage and pointers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_data_q[i] <= '0;
      end
      fifo_last_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
    end else begin
      if (push) begin
        fifo_data_q[wr_ptr_q] <= ram_data;
        fifo_last_q[wr_ptr_q] <= pipe_last_q[READ_LATENCY-1];
        wr_ptr_q              <= wr_ptr_q + FIFO_DEPTH_LOG2'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + FIFO_DEPTH_LOG2'(1);
      end
    end
  end

  // FIFO occupancy; simultaneous push and pop leave it unchanged.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fifo_count_q <= '0;
    end else begin
      case ({push, pop})
        2'b10:   fifo_count_q <= fifo_count_q + CNT_W'(1);
        2'b01:   fifo_count_q <= fifo_count_q - CNT_W'(1);
        default: fifo_count_q <= fifo_count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_read_streamer.sv
// Bench for ram_read_streamer with a 2-cycle RAM model holding addr[7:0].
module tb_ram_read_streamer;
  localparam int DW = 8;
  localparam int AW = 12;
  localparam int LW = 13;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [LW-1:0] length = '0;
`ifdef RAM_READ_STREAMER_LOOP_EN
  logic          loop = 1'b0;
`endif
  logic          busy, done, m_valid, m_last;
  logic          m_ready = 1'b1;
  logic [AW-1:0] ram_read_addr;
  logic [DW-1:0] ram_data, m_data;
  logic [DW-1:0] ram_r1 = '0, ram_r2 = '0;

  ram_read_streamer dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .base_addr(base_addr), .length(length),
`ifdef RAM_READ_STREAMER_LOOP_EN
    .loop(loop),
`endif
    .busy(busy), .done(done), .ram_read_addr(ram_read_addr),
    .ram_data(ram_data), .m_data(m_data), .m_valid(m_valid),
    .m_ready(m_ready), .m_last(m_last)
  );

  always #5 clk = ~clk;

  // RAM read port: address sampled at edge, data out one edge later.
  always @(posedge clk) begin
    ram_r1 <= ram_read_addr[7:0];
    ram_r2 <= ram_r1;
  end
  assign ram_data = ram_r2;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mon_exp;
  int beats = 0;
  int last_beat_cyc = -1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every transferred beat must match the oldest expected word.
  always @(negedge clk) begin
    if (reset_n && m_valid && m_ready) begin
      check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        mon_exp = exp_q.pop_front();
        check("beat", {23'd0, m_last, m_data}, mon_exp);
      end
      beats++;
      if (m_last) last_beat_cyc = cyc;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [AW-1:0] b, input logic [LW-1:0] l, output int c0);
    logic [AW-1:0] a;
    c0 = cyc;
    start = 1'b1;
    base_addr = b;
    length = l;
    for (int i = 0; i < int'(l); i++) begin
      a = b + AW'(i);
      exp_q.push_back({23'd0, (i == int'(l) - 1), a[7:0]});
    end
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc, input bit rand_ready, input int inject_at,
                           output int dcyc);
    bit seen;
    seen = 1'b0;
    dcyc = -1;
    for (int k = 0; k < max_cyc && !seen; k++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        dcyc = cyc;
      end
      tick();
      if (rand_ready) m_ready = 1'($urandom_range(0, 1));
      start = (k == inject_at);
    end
    start = 1'b0;
    check("done_seen", 32'(seen), 32'd1);
    @(negedge clk);
    check("done_one_cycle", 32'(done), 32'd0);
    tick();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},  32'(busy), 32'd0);
    check({tag, "_done"},  32'(done), 32'd0);
    check({tag, "_valid"}, 32'(m_valid), 32'd0);
    check({tag, "_last"},  32'(m_last), 32'd0);
    check({tag, "_addr"},  32'(ram_read_addr), 32'd0);
    check({tag, "_data"},  32'(m_data), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog cycles=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c0, d, fv, b0, a0;
    logic any_valid;
    logic [AW-1:0] wrap_exp [4];
    wrap_exp = '{12'hFFE, 12'hFFF, 12'h000, 12'h001};

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    reset_n = 1'b1;
    repeat (2) tick();

    // Basic 8-beat burst, latency and back-to-back beats.
    do_start(12'h010, 13'd8, c0);
    fv = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (m_valid) begin
        fv = cyc;
        break;
      end
    end
    check("first_valid_lat", 32'(fv - c0), 32'd4);
    check("busy_active", 32'(busy), 32'd1);
    tick();
    wait_done(60, 1'b0, -1, d);
    check("done_after_last", 32'(d - last_beat_cyc), 32'd1);
    check("burst_span", 32'(last_beat_cyc - fv), 32'd7);
    check("sb_drained_t1", 32'(exp_q.size()), 32'd0);

    // Address wrap at the top of the RAM.
    do_start(12'hFFE, 13'd4, c0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("wrap_addr", 32'(ram_read_addr), 32'(wrap_exp[k]));
    end
    tick();
    wait_done(60, 1'b0, -1, d);
    check("sb_drained_t2", 32'(exp_q.size()), 32'd0);

    // Backpressure: 10 cycles with m_ready low, only FIFO-depth words issue.
    m_ready = 1'b0;
    do_start(12'h020, 13'd16, c0);
    repeat (9) @(negedge clk);
    check("stall_addr", 32'(ram_read_addr), 32'h024);
    check("stall_valid", 32'(m_valid), 32'd1);
    check("stall_head", 32'(m_data), 32'h20);
    tick();
    m_ready = 1'b1;
    wait_done(100, 1'b0, -1, d);
    check("sb_drained_t3", 32'(exp_q.size()), 32'd0);

    // Zero-length request.
    a0 = int'(ram_read_addr);
    do_start(12'h0AB, 13'd0, c0);
    @(negedge clk);
    check("len0_done", 32'(done), 32'd1);
    check("len0_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("len0_done_gone", 32'(done), 32'd0);
    check("len0_busy_after", 32'(busy), 32'd0);
    check("len0_addr", 32'(ram_read_addr), 32'(a0));
    tick();

    // Reset mid-transfer after 3 beats, then a fresh transfer.
    b0 = beats;
    do_start(12'h040, 13'd16, c0);
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      #1;
      if (beats - b0 >= 3) break;
    end
    check("pre_reset_beats", 32'(beats - b0), 32'd3);
    tick();
    reset_n = 1'b0;
    exp_q.delete();
    #1;
    check_reset_outputs("midrst");
    repeat (2) tick();
    reset_n = 1'b1;
    any_valid = 1'b0;
    repeat (4) begin
      @(negedge clk);
      any_valid |= m_valid;
    end
    check("no_stale_valid", 32'(any_valid), 32'd0);
    tick();
    do_start(12'h100, 13'd8, c0);
    wait_done(60, 1'b0, -1, d);
    check("sb_drained_t5", 32'(exp_q.size()), 32'd0);

    // Long run with random backpressure and an ignored mid-run start.
    b0 = beats;
    do_start(12'h300, 13'd200, c0);
    base_addr = 12'h555;
    length = 13'd7;
    wait_done(3000, 1'b1, 50, d);
    m_ready = 1'b1;
    check("rand_beats", 32'(beats - b0), 32'd200);
    check("sb_drained_t6", 32'(exp_q.size()), 32'd0);
    repeat (4) @(negedge clk);
    check("idle_after_rand", 32'(busy | m_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
